// File: rtl/serial_word_serializer.sv
// serial_word_serializer: parallel-to-serial converter feeding the 101 detector.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock, back-to-back with no idle gap, with word_start/word_done framing.
// Optional build macro SER_PARITY_EN appends an even-parity bit to every frame.
module serial_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_d, ser_valid_d, word_start_d, word_done_d, busy_d;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_value;
    logic [CW-1:0]    cnt_next;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Ready in IDLE, and on the last frame bit so the next word loads seamlessly
    always_comb begin
        data_ready = (state_q == IDLE) || (cnt_q == LAST_CNT);
        accept     = data_valid && data_ready;
        cnt_next   = cnt_q + ONE_CNT;
        if (MSB_FIRST) begin
            first_bit  = data_in[WIDTH-1];
            load_value = data_in << 1;
            next_bit   = shift_q[WIDTH-1];
        end else begin
            first_bit  = data_in[0];
            load_value = data_in >> 1;
            next_bit   = shift_q[0];
        end
    end

    // State, shift register, counter and registered outputs with async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            word_start <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ser_out    <= ser_out_d;
            ser_valid  <= ser_valid_d;
            word_start <= word_start_d;
            word_done  <= word_done_d;
            busy       <= busy_d;
`ifdef SER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next state: load on accept, advance while shifting, return to IDLE after the last bit
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            shift_d = load_value;
            cnt_d   = ONE_CNT;
`ifdef SER_PARITY_EN
            parity_d = ^data_in;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST_CNT) begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                cnt_d   = cnt_next;
            end
        end
    end

    // Next values of the registered serial outputs and framing strobes
    always_comb begin
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        word_start_d = 1'b0;
        word_done_d  = 1'b0;
        busy_d       = 1'b0;
        if (accept) begin
            ser_out_d    = first_bit;
            ser_valid_d  = 1'b1;
            word_start_d = 1'b1;
            busy_d       = 1'b1;
        end else if (state_q == SHIFT && cnt_q != LAST_CNT) begin
`ifdef SER_PARITY_EN
            ser_out_d = (cnt_q == DATA_CNT) ? parity_q : next_bit;
`else
            ser_out_d = next_bit;
`endif
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
            word_done_d = (cnt_next == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_serial_word_serializer.sv
// Directed self-checking bench for serial_word_serializer.
// One MSB-first instance carries most scenarios; an LSB-first instance covers bit order.
// Parity frames are exercised when SER_PARITY_EN is defined.
module tb_serial_word_serializer;

`ifdef SER_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, ser_out, ser_valid, word_start, word_done, busy;
    logic [7:0] l_data_in;
    logic       l_data_valid;
    logic       l_data_ready, l_ser_out, l_ser_valid, l_word_start, l_word_done, l_busy;

    int checks = 0;
    int errors = 0;

    serial_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .word_start(word_start), .word_done(word_done), .busy(busy)
    );

    serial_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(l_data_in), .data_valid(l_data_valid),
        .data_ready(l_data_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
        .word_start(l_word_start), .word_done(l_word_done), .busy(l_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Expected frame bit i of a word: data bits in the chosen order, then even parity
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid = 1'b0;
        data_in = 8'h00;
        l_data_valid = 1'b0;
        l_data_in = 8'h00;
        step();
        checks++;
        if ({ser_out, ser_valid, word_start, word_done, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 00000", {ser_out, ser_valid, word_start, word_done, busy});
        end
        rst = 1'b0;
        step();
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b want 1", data_ready);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp;
        data_in = 8'hA5;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        data_in = 8'hFF;
        for (int i = 0; i < FB; i++) begin
            exp = {exp_bit(8'hA5, i, 1'b1), 1'b1, i == 0, i == FB - 1};
            checks++;
            if ({ser_out, ser_valid, word_start, word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL single_bit%0d got %b want %b", i, {ser_out, ser_valid, word_start, word_done}, exp);
            end
            step();
        end
        checks++;
        if ({ser_out, ser_valid, word_done, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_idle got %b want 0000", {ser_out, ser_valid, word_done, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        logic [7:0] w;
        int k;
        data_in = 8'hC3;
        data_valid = 1'b1;
        step();
        data_in = 8'h3C;
        for (int i = 0; i < 2 * FB; i++) begin
            w = (i < FB) ? 8'hC3 : 8'h3C;
            k = i % FB;
            exp = {exp_bit(w, k, 1'b1), 1'b1, k == 0, k == FB - 1};
            checks++;
            if ({ser_out, ser_valid, word_start, word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_bit%0d got %b want %b", i, {ser_out, ser_valid, word_start, word_done}, exp);
            end
            if (i == FB - 1) begin
                checks++;
                if (data_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready_on_done got %b want 1", data_ready);
                end
            end
            if (i == FB) data_valid = 1'b0;
            step();
        end
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end_valid got %b want 0", ser_valid);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp;
        logic [7:0] w;
        int k;
        data_in = 8'hF0;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 2 * FB; i++) begin
            if (i == 2) begin
                data_in = 8'h81;
                data_valid = 1'b1;
            end
            w = (i < FB) ? 8'hF0 : 8'h81;
            k = i % FB;
            if (i >= 2 && i < FB) begin
                checks++;
                if (data_ready !== (k == FB - 1)) begin
                    errors++;
                    $display("[TB] FAIL stall_ready_cyc%0d got %b want %b", i + 1, data_ready, k == FB - 1);
                end
            end
            exp = {exp_bit(w, k, 1'b1), 1'b1, k == 0, k == FB - 1};
            checks++;
            if ({ser_out, ser_valid, word_start, word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL stall_bit%0d got %b want %b", i, {ser_out, ser_valid, word_start, word_done}, exp);
            end
            if (i == FB) data_valid = 1'b0;
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_end_busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp;
        data_in = 8'hAA;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_out, ser_valid, word_start, word_done, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async got %b want 00000", {ser_out, ser_valid, word_start, word_done, busy});
        end
        #1;
        rst = 1'b0;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_ready got %b want 1", data_ready);
        end
        data_in = 8'h40;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            exp = {exp_bit(8'h40, i, 1'b1), 1'b1, i == 0, i == FB - 1};
            checks++;
            if ({ser_out, ser_valid, word_start, word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL midreset_bit%0d got %b want %b", i, {ser_out, ser_valid, word_start, word_done}, exp);
            end
            step();
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp;
        logic [2:0] hist;
        int hits;
        int hit_at;
        hist = 3'b000;
        hits = 0;
        hit_at = -1;
        l_data_in = 8'h05;
        l_data_valid = 1'b1;
        step();
        l_data_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            exp = {exp_bit(8'h05, i, 1'b0), 1'b1, i == 0, i == FB - 1};
            checks++;
            if ({l_ser_out, l_ser_valid, l_word_start, l_word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL lsb_bit%0d got %b want %b", i, {l_ser_out, l_ser_valid, l_word_start, l_word_done}, exp);
            end
            hist = {hist[1:0], l_ser_out};
            if (hist == 3'b101) begin
                hits++;
                hit_at = i;
            end
            step();
        end
        checks++;
        if (hits != 1 || hit_at != 2) begin
            errors++;
            $display("[TB] FAIL lsb_detect got hits=%0d at=%0d want hits=1 at=2", hits, hit_at);
        end
        checks++;
        if (l_ser_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lsb_end_valid got %b want 0", l_ser_valid);
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [3:0] exp;
        logic [7:0] w;
        int k;
        data_in = 8'h07;
        data_valid = 1'b1;
        step();
        data_in = 8'h03;
        for (int i = 0; i < 18; i++) begin
            w = (i < 9) ? 8'h07 : 8'h03;
            k = i % 9;
            exp = {exp_bit(w, k, 1'b1), 1'b1, k == 0, k == 8};
            if (i == 8) exp[3] = 1'b1;
            if (i == 17) exp[3] = 1'b0;
            checks++;
            if ({ser_out, ser_valid, word_start, word_done} !== exp) begin
                errors++;
                $display("[TB] FAIL parity_bit%0d got %b want %b", i, {ser_out, ser_valid, word_start, word_done}, exp);
            end
            if (i == 9) data_valid = 1'b0;
            step();
        end
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_end_valid got %b want 0", ser_valid);
        end
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_lsb_first();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_serializer.md
Name: serial_word_serializer

Overview:
Parallel-to-serial converter that sits directly upstream of the 101 sequence detector and drives its serial input bit, one bit per clock. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out back-to-back with no idle gap when words are available. It adds framing strobes so downstream stages and the bench can align bit streams to word boundaries.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in holds a valid word
data_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial bit, connects to detector serial input
ser_valid  output  1  ser_out carries a real bit this cycle
word_start  output  1  ser_out holds the first bit of a word
word_done  output  1  ser_out holds the last bit of a word
busy  output  1  word in progress (state == SHIFT)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On rst assertion, immediately and without waiting for a clock edge: state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, word_start=0, word_done=0, busy=0.
- Registered outputs: ser_out, ser_valid, word_start, word_done, busy. Combinational output: data_ready.
- States: IDLE, SHIFT. FRAME_BITS = WIDTH, or WIDTH+1 with the optional feature.
- data_ready = 1 in IDLE; also 1 in SHIFT on the cycle ser_out holds the last frame bit. Otherwise 0.
- Accept = data_valid && data_ready at a rising edge. data_in is sampled only on accept. Changes to data_in while data_ready=0 are ignored.
- On accept: load the word. On that same edge, ser_out takes the first bit, with ser_valid=1, word_start=1, busy=1, counter=1, and state=SHIFT.
- Latency: first bit is visible on ser_out the cycle after the accept edge.
- SHIFT, not on the last bit: each edge presents the next bit. ser_valid=1, word_start=0, counter increments.
- Last bit: word_done=1 on the cycle ser_out holds bit FRAME_BITS-1. At the following edge:
  - If accept occurs: start the next word seamlessly (first bit, word_start=1, counter=1). There is no bubble, so a continuous stream of words gives continuous ser_valid=1.
  - If no accept: state=IDLE, ser_valid=0, ser_out=0, busy=0, word_done=0.
- Bit order: MSB_FIRST=1 gives bits WIDTH-1 down to 0; MSB_FIRST=0 gives bits 0 up to WIDTH-1.
- Counter width: $clog2(WIDTH+2). The counter never exceeds FRAME_BITS and wraps to 1 on a seamless reload.
- Reset mid-word: the partial word is discarded immediately. After reset release, the first valid word is accepted at the first edge (data_ready=1).
- data_valid with data_ready=0 stalls; the word is held by the source until accepted. There is no loss and no duplication.

Optional Feature:
SER_PARITY_EN
- Defined: each frame appends one even-parity bit (XOR of all WIDTH data bits) after the data bits, so FRAME_BITS = WIDTH+1. word_done is asserted with the parity bit, not the last data bit. data_ready rises on the parity-bit cycle.
- Not defined: FRAME_BITS = WIDTH, with no parity logic.

Test Plan:
1. Reset with rst=1 mid-stream, no clock edge -> ser_out=0, ser_valid=0, busy=0, word_done=0 asynchronously; data_ready=1 after release.
2. Single word 8'hA5, MSB_FIRST=1 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; word_start on cycle 1, word_done on cycle 8; ser_valid=0 on cycle 9.
3. Back-to-back 8'hC3 then 8'h3C, data_valid held high -> 16 consecutive ser_valid=1 cycles; stream 11000011 00111100; second accept on the word_done cycle of the first word.
4. Stall: new word presented during cycle 3 of the current word -> data_ready=0 until cycle 8; new word's first bit on cycle 9; the in-flight word is not corrupted.
5. MSB_FIRST=0, word 8'h05 -> ser_out 1,0,1,0,0,0,0,0. Fed into the 101 detector, detect asserts exactly once, one cycle after the third bit.
6. SER_PARITY_EN, words 8'h07 then 8'h03 -> 9-bit frames; parity bits 1 and 0 respectively; word_done on the 9th bit of each frame; no gap between frames.
